// File: rtl/hyperram_bus_arbiter.sv
// hyperram_bus_arbiter: two-port round-robin owner of the shared HyperRAM pad bus.
// Drives the pad-mux select/tri-state, with a fixed turnaround gap and hung-owner revocation.
module hyperram_bus_arbiter #(
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 1024,
  parameter int HOLD_W = 16
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iReq1,
  input  logic iReq2,
  input  logic iOe1,
  input  logic iOe2,
  output logic oGnt1,
  output logic oGnt2,
  output logic oWhichWr,
  output logic oTriState,
  output logic oTimeout
);
  typedef enum logic [1:0] {IDLE, OWN1, OWN2, TURN} stateT;
  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  stateT state, nextState;
  logic [3:0] turnCnt;
  logic [HOLD_W-1:0] holdCnt;
  logic lastOwner, lock1, lock2, eff1, eff2, owning, ownerReq, timeoutHit, newOwn;
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
      turnCnt <= '0;
      holdCnt <= '0;
      lastOwner <= 1'b1;
      oWhichWr <= 1'b0;
      oTimeout <= 1'b0;
      lock1 <= 1'b0;
      lock2 <= 1'b0;
    end else begin
      state <= nextState;
      turnCnt <= state == TURN ? turnCnt - 1'b1 : TURN_LOAD;
      holdCnt <= owning ? holdCnt + 1'b1 : '0;
      lastOwner <= newOwn ? nextState == OWN2 : lastOwner;
      oWhichWr <= newOwn ? nextState == OWN2 : oWhichWr;
      oTimeout <= timeoutHit;
      // a lock survives until its port is seen idle once
      lock1 <= (timeoutHit && state == OWN1) || (lock1 && iReq1);
      lock2 <= (timeoutHit && state == OWN2) || (lock2 && iReq2);
    end
  end
  always_comb begin
    eff1 = iReq1 && !lock1;
    eff2 = iReq2 && !lock2;
    owning = state == OWN1 || state == OWN2;
    ownerReq = state == OWN2 ? iReq2 : iReq1;
    timeoutHit = owning && ownerReq && MAX_HOLD != 0 && holdCnt == HOLD_LAST;
    nextState = state;
    case (state)
      IDLE: nextState = (eff1 && (!eff2 || lastOwner)) ? OWN1 : eff2 ? OWN2 : IDLE;
      OWN1, OWN2: nextState = (!ownerReq || timeoutHit) ? TURN : state;
      default: nextState = turnCnt == '0 ? IDLE : TURN;
    endcase
    newOwn = state == IDLE && nextState != IDLE;
  end
  always_comb begin
    oGnt1 = state == OWN1;
    oGnt2 = state == OWN2;
    oTriState = (oGnt1 && iOe1) || (oGnt2 && iOe2);
  end
endmodule

// File: tb/tb_hyperram_bus_arbiter.sv
// tb_hyperram_bus_arbiter: directed checks of grant timing, fairness, timeout lockout and reset.
module tb_hyperram_bus_arbiter;
  logic iClk, iRst, iReq1, iReq2, iOe1, iOe2;
  logic oGnt1, oGnt2, oWhichWr, oTriState, oTimeout;
  int nChecks = 0;
  int nFails = 0;
  hyperram_bus_arbiter #(.TURN_CYC(2), .MAX_HOLD(8), .HOLD_W(16)) dut (
    .iClk(iClk), .iRst(iRst), .iReq1(iReq1), .iReq2(iReq2), .iOe1(iOe1), .iOe2(iOe2),
    .oGnt1(oGnt1), .oGnt2(oGnt2), .oWhichWr(oWhichWr), .oTriState(oTriState), .oTimeout(oTimeout)
  );
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask
  task automatic applyReset();
    iRst = 1'b1;
    iReq1 = 1'b0;
    iReq2 = 1'b0;
    iOe1 = 1'b0;
    iOe2 = 1'b0;
    tick(2);
    iRst = 1'b0;
  endtask
  initial begin
    iRst = 1'b1;
    iReq1 = 1'b0;
    iReq2 = 1'b0;
    iOe1 = 1'b0;
    iOe2 = 1'b0;
    tick(2);
    check("rst_gnt", {oGnt2, oGnt1}, 2'b00);
    check("rst_which", oWhichWr, 0);
    check("rst_tri", oTriState, 0);
    check("rst_tmo", oTimeout, 0);
    iRst = 1'b0;
    // single requester, then a request raised during turnaround
    iReq1 = 1'b1;
    iOe1 = 1'b1;
    check("t1_idle_tri", oTriState, 0);
    tick(1);
    check("t1_gnt", {oGnt2, oGnt1}, 2'b01);
    check("t1_which", oWhichWr, 0);
    check("t1_tri", oTriState, 1);
    tick(4);
    check("t1_hold", oGnt1, 1);
    iReq1 = 1'b0;
    tick(1);
    check("t1_drop", oGnt1, 0);
    check("t1_drop_tri", oTriState, 0);
    iReq1 = 1'b1;
    tick(1);
    check("t1_turn1", oGnt1, 0);
    tick(1);
    check("t1_idle", oGnt1, 0);
    tick(1);
    check("t1_regrant", oGnt1, 1);
    // simultaneous requests after reset
    applyReset();
    iReq1 = 1'b1;
    iReq2 = 1'b1;
    tick(1);
    check("t2_first", {oGnt2, oGnt1}, 2'b01);
    iReq1 = 1'b0;
    tick(1);
    check("t2_drop", {oGnt2, oGnt1}, 2'b00);
    tick(1);
    check("t2_gap1", {oGnt2, oGnt1}, 2'b00);
    check("t2_which_turn", oWhichWr, 0);
    tick(1);
    check("t2_gap2", {oGnt2, oGnt1}, 2'b00);
    tick(1);
    check("t2_gnt2", {oGnt2, oGnt1}, 2'b10);
    check("t2_which", oWhichWr, 1);
    iReq2 = 1'b0;
    tick(1);
    check("t2_rel", oGnt2, 0);
    check("t2_which_held", oWhichWr, 1);
    tick(2);
    check("t2_which_idle", oWhichWr, 1);
    // both always requesting: strict alternation
    applyReset();
    iReq1 = 1'b1;
    iReq2 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      int w;
      logic [1:0] expOwn;
      w = 0;
      expOwn = (g % 2) != 0 ? 2'b10 : 2'b01;
      while (!(oGnt1 || oGnt2) && w < 10) begin
        tick(1);
        w++;
        check("t3_excl", {31'd0, oGnt1 && oGnt2}, 0);
      end
      check("t3_owner", {oGnt2, oGnt1}, expOwn);
      check("t3_gap", w, g == 0 ? 1 : 3);
      repeat (3) begin
        tick(1);
        check("t3_hold", {oGnt2, oGnt1}, expOwn);
      end
      if (expOwn[0]) iReq1 = 1'b0;
      else iReq2 = 1'b0;
      tick(1);
      check("t3_rel", {oGnt2, oGnt1}, 2'b00);
      iReq1 = 1'b1;
      iReq2 = 1'b1;
    end
    // hung owner: forced revoke, lockout, then recovery
    applyReset();
    iReq2 = 1'b1;
    tick(8);
    check("t4_last_gnt", oGnt2, 1);
    check("t4_no_tmo", oTimeout, 0);
    tick(1);
    check("t4_revoke", oGnt2, 0);
    check("t4_tmo", oTimeout, 1);
    tick(1);
    check("t4_tmo_pulse", oTimeout, 0);
    repeat (10) begin
      tick(1);
      check("t4_locked", {oGnt2, oGnt1}, 2'b00);
    end
    iReq2 = 1'b0;
    tick(1);
    iReq2 = 1'b1;
    tick(1);
    check("t4_regrant", oGnt2, 1);
    check("t4_regrant_tmo", oTimeout, 0);
    // release coinciding with the timeout edge counts as voluntary
    applyReset();
    iReq2 = 1'b1;
    tick(8);
    iReq2 = 1'b0;
    tick(1);
    check("t4v_drop", oGnt2, 0);
    check("t4v_no_tmo", oTimeout, 0);
    iReq2 = 1'b1;
    tick(3);
    check("t4v_no_lock", oGnt2, 1);
    // drive enable follows the owner only, combinationally
    applyReset();
    iReq1 = 1'b1;
    iOe2 = 1'b1;
    tick(1);
    check("t5_gnt", oGnt1, 1);
    check("t5_tri0", oTriState, 0);
    #1 iOe1 = 1'b1;
    #1 check("t5_tri1", oTriState, 1);
    iOe1 = 1'b0;
    #1 check("t5_tri2", oTriState, 0);
    // asynchronous reset mid-grant
    applyReset();
    iReq2 = 1'b1;
    iOe2 = 1'b1;
    tick(1);
    check("t6_pre", {oGnt2, oGnt1, oTriState}, 3'b101);
    #3 iRst = 1'b1;
    #1 check("t6_async", {oGnt2, oGnt1, oTriState}, 3'b000);
    iReq1 = 1'b1;
    tick(1);
    iRst = 1'b0;
    tick(1);
    check("t6_tie", {oGnt2, oGnt1}, 2'b01);
    check("t6_which", oWhichWr, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/hyperram_bus_arbiter.md
Name: hyperram_bus_arbiter

Overview:
Arbitrates ownership of the shared HyperRAM pad bus between two requesting FPGAs, FPGA-1# and FPGA-2#. It sits directly upstream of the per-pin pad muxes. It drives their write-select (port-2 select) and tri-state enable on every DQ/RWDS pin. It guarantees:
- only one owner at a time;
- a fixed bus-turnaround gap between owners;
- round-robin fairness;
- forced revocation of a hung owner.

Parameters:
- TURN_CYC, 2, idle cycles with the bus released between owners; legal 1..15.
- MAX_HOLD, 1024, maximum consecutive grant cycles before forced revoke; 0 disables the timeout; legal 0..65535.
- HOLD_W, 16, hold-counter width; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  asynchronous, active-high reset.
- iReq1  in  1  FPGA-1# bus request; held high for the whole transaction, dropped to release.
- iReq2  in  1  FPGA-2# bus request; same rules.
- iOe1  in  1  FPGA-1# wants to drive the pads (1 = drive); honoured only while FPGA-1# owns the bus.
- iOe2  in  1  FPGA-2# drive request; same rules.
- oGnt1  out  1  FPGA-1# owns the bus.
- oGnt2  out  1  FPGA-2# owns the bus.
- oWhichWr  out  1  pad-mux write select; 0 = FPGA-1#, 1 = FPGA-2#.
- oTriState  out  1  pad-mux tri-state control; 1 = drive, 0 = High-Z.
- oTimeout  out  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; oGnt1 = oGnt2 = 0; oWhichWr = 0; oTriState = 0; oTimeout = 0; turn and hold counters = 0; lastOwner = 1 (FPGA-1# wins the first tie); both lockout masks cleared. Reset mid-grant releases the pads (High-Z) immediately.
- States: IDLE, OWN1, OWN2, TURN.
- IDLE:
  - Effective request = iReqN & ~lockN.
  - Only one effective request: go to the matching OWN state at the next edge.
  - Both effective: the port ≠ lastOwner wins.
  - Neither: stay in IDLE.
- Grant latency: a request sampled high in IDLE at edge n gives oGntN = 1 and updated oWhichWr at edge n+1. oGnt1 and oGnt2 are registered and never both high.
- OWNx:
  - oGntx = 1; oWhichWr = x-1; lastOwner = x; the hold counter increments each cycle.
  - Owner's iReqx low at an edge: grant drops at that edge, turn counter loads TURN_CYC-1, go to TURN.
  - A request from the other port does not pre-empt the owner.
- Timeout: in OWNx with MAX_HOLD≠0, when the hold counter reaches MAX_HOLD-1 (i.e. MAX_HOLD grant cycles):
  - the grant drops at the next edge;
  - oTimeout = 1 for exactly that one cycle;
  - lockx is set and the state goes to TURN;
  - lockx clears at the first edge where iReqx is sampled low.
  - Timeout and a voluntary release in the same cycle are treated as a voluntary release: no pulse, no lock.
- TURN:
  - lasts exactly TURN_CYC cycles, then returns to IDLE;
  - all grants low; requests are ignored until IDLE;
  - oWhichWr holds its last value through TURN and IDLE so the pad mux select never glitches.
- oTriState is combinational: (oGnt1 & iOe1) | (oGnt2 & iOe2). It is 0 in IDLE and TURN whatever iOe is. This is the only combinational output.
- Re-grant: the minimum gap from a grant dropping to the next grant rising is TURN_CYC+1 cycles (TURN plus one IDLE arbitration cycle).
- The hold counter clears on every OWN entry. Its width must not wrap before MAX_HOLD.

Test Plan:
1. Reset, then raise iReq1 alone for 5 cycles with iOe1 = 1. Expect oGnt1 = 1 one cycle after iReq1 rises, oWhichWr = 0, oTriState = 1. After iReq1 drops, expect oGnt1 = 0 and oTriState = 0 at the next edge, and TURN lasting 2 cycles.
2. Raise iReq1 and iReq2 on the same edge after reset. Expect FPGA-1# granted first. Drop iReq1 with iReq2 still held: expect oGnt2 = 1 exactly 3 cycles after oGnt1 falls, with oWhichWr = 1 and held at 1 after the release.
3. Keep both requests permanently asserted, each owner releasing after 4 cycles and re-requesting 1 cycle later. Expect strict alternation 1,2,1,2 with no double grant on any cycle.
4. MAX_HOLD = 8; hold iReq2 high for 20 cycles. Expect oGnt2 to drop after 8 grant cycles with a single-cycle oTimeout pulse. FPGA-2# gets no re-grant while iReq2 stays high. After iReq2 drops for 1 cycle and rises again, expect a normal grant.
5. During OWN1 toggle iOe1 0/1/0 and hold iOe2 = 1. Expect oTriState to follow iOe1 combinationally, with iOe2 having no effect.
6. Assert iRst asynchronously mid-grant (between clock edges). Expect oGnt1/oGnt2/oTriState = 0 immediately, and after release an IDLE start with FPGA-1# winning the first tie.
